// File: rtl/jk_pkg.sv
// Shared definitions for the JK command sequencer.
//   - command encodings as {j,k}
//   - sequencer FSM state encodings
//   - apply_cmd(): latch-q effect of one completed command
package jk_pkg;

    typedef enum logic [1:0] {
        CMD_HOLD = 2'b00,
        CMD_CLR  = 2'b01,
        CMD_SET  = 2'b10,
        CMD_TOG  = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_GAP   = 2'b10
    } state_e;

    // Next q of a JK latch after a {j,k} pulse.
    function automatic logic apply_cmd(input logic q, input logic [1:0] jk);
        logic r;
        case (jk)
            CMD_CLR: r = 1'b0;
            CMD_SET: r = 1'b1;
            CMD_TOG: r = ~q;
            default: r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Command FIFO, DEPTH x 2-bit, show-ahead read (dout = head entry).
// Ports:
//   clk, rst       clock, async active-low reset (empties the FIFO)
//   push, din      write din when push && !full
//   pop            drop head entry when pop && !empty
//   dout           head entry (valid while !empty)
//   full, empty    occupancy flags
// Pointers carry one extra wrap bit so full/empty are told apart
// without a separate counter.
module jk_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [1:0] din,
    output logic [1:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0]  mem [DEPTH];
    logic [AW:0] wptr, rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + (AW+1)'(1);
            if (pop && !empty) rptr <= rptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Upstream driver for the JK latch stage. Queues HOLD/CLR/SET/TOGGLE
// commands and plays each as a PULSE_CYC-cycle j/k pulse followed by
// GAP_CYC cycles of j=k=0. Tracks the expected latch output in q_model.
// Ports:
//   clk, rst          clock, async active-low reset
//   cmd_valid, cmd    command in ({j,k}); accepted when cmd_ready
//   cmd_ready         FIFO not full
//   j, k              registered drive to the latch stage
//   busy              FIFO non-empty or a command period in progress
//   q_model           expected latch q after the last completed pulse
//   issued_cnt        commands whose pulse completed (wraps)
module jk_cmd_sequencer
    import jk_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PULSE_CYC = 1,
    parameter int GAP_CYC   = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic             cmd_ready,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             q_model,
    output logic [CNT_W-1:0] issued_cnt
);
    localparam int MAXC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);

    state_e           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [1:0]       jk_n;
    logic             q_n;
    logic [CNT_W-1:0] iss_n;
    logic             pop, full, empty;
    logic [1:0]       head;

    assign cmd_ready = !full;
    assign busy      = !empty || (state != ST_IDLE);

    jk_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .pop   (pop),
        .din   (cmd),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            j          <= 1'b0;
            k          <= 1'b0;
            q_model    <= 1'b0;
            issued_cnt <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            {j, k}     <= jk_n;
            q_model    <= q_n;
            issued_cnt <= iss_n;
        end
    end

    // j/k themselves hold the in-flight command, so the q update at the
    // end of DRIVE reads them directly instead of a separate copy.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        jk_n    = {j, k};
        q_n     = q_model;
        iss_n   = issued_cnt;
        pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    jk_n    = head;
                    cnt_n   = PULSE_LD;
                    state_n = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt == '0) begin
                    jk_n    = 2'b00;
                    q_n     = apply_cmd(q_model, {j, k});
                    iss_n   = issued_cnt + CNT_W'(1);
                    cnt_n   = GAP_LD;
                    state_n = ST_GAP;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    // Back-to-back: skip IDLE when work is already queued.
                    if (!empty) begin
                        pop     = 1'b1;
                        jk_n    = head;
                        cnt_n   = PULSE_LD;
                        state_n = ST_DRIVE;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer. Two instances share stimulus:
//   A: PULSE=1, GAP=1, CNT_W=8    B: PULSE=3, GAP=2, CNT_W=2
// Every cycle both are compared against a schedule-based model: each
// accepted command gets an accept edge a and a start edge
// s = max(a+1, prev_s+PULSE+GAP); all outputs follow from those times.
module tb_jk_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;

    logic       ra, ja, ka, ba, qa;
    logic [7:0] ca;
    logic       rb, jb, kb, bb, qb;
    logic [1:0] cb;

    always #5 clk = ~clk;

    jk_cmd_sequencer #(.DEPTH(4), .PULSE_CYC(1), .GAP_CYC(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(ra),
        .j(ja), .k(ka), .busy(ba), .q_model(qa), .issued_cnt(ca));

    jk_cmd_sequencer #(.DEPTH(4), .PULSE_CYC(3), .GAP_CYC(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(rb),
        .j(jb), .k(kb), .busy(bb), .q_model(qb), .issued_cnt(cb));

    // Observed vector: {ready, j, k, busy, q, cnt[7:0]}
    wire [12:0] act_a = {ra, ja, ka, ba, qa, ca};
    wire [12:0] act_b = {rb, jb, kb, bb, qb, 6'b0, cb};

    int n_cmp = 0;
    int n_bad = 0;
    int ecnt  = 0;

    typedef struct {
        int         d;
        logic [1:0] c;
        int         a;
        int         s;
    } rec_t;

    rec_t recs[$];
    int   last_s[2];

    typedef struct {
        logic        v;
        logic [1:0]  c;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[12];

    function automatic int p_of(int d); return (d != 0) ? 3 : 1; endfunction
    function automatic int g_of(int d); return (d != 0) ? 2 : 1; endfunction
    function automatic int w_of(int d); return (d != 0) ? 2 : 8; endfunction

    // Expected outputs of instance d just after edge e.
    function automatic logic [12:0] model_exp(int d, int e);
        int         p = p_of(d);
        int         g = g_of(d);
        int         infifo = 0;
        int         done = 0;
        logic       q = 1'b0;
        logic [1:0] jk = 2'b00;
        logic       bsy = 1'b0;
        foreach (recs[i]) begin
            if (recs[i].d == d) begin
                if (recs[i].a <= e && e < recs[i].s) infifo++;
                if (recs[i].s <= e && e < recs[i].s + p) jk = recs[i].c;
                if (recs[i].s + p <= e) begin
                    done++;
                    if (recs[i].c == 2'b01) q = 1'b0;
                    else if (recs[i].c == 2'b10) q = 1'b1;
                    else if (recs[i].c == 2'b11) q = ~q;
                end
                if (recs[i].a <= e && e < recs[i].s + p + g) bsy = 1'b1;
            end
        end
        done = done % (1 << w_of(d));
        return {(infifo < 4), jk, bsy, q, 8'(done)};
    endfunction

    function automatic logic [12:0] ex(int r, int jk, int b, int q, int c);
        return {1'(r), 2'(jk), 1'(b), 1'(q), 8'(c)};
    endfunction

    task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s edge %0d: got %b want %b", name, ecnt, act, exp);
        end
    endtask

    task automatic model_clear();
        recs.delete();
        last_s[0] = -1000;
        last_s[1] = -1000;
    endtask

    // Drive inputs for the next edge, log acceptance in the model,
    // clock once and compare both instances.
    task automatic step(input logic v, input logic [1:0] c);
        logic [12:0] now;
        rec_t        r;
        cmd_valid = v;
        cmd       = c;
        for (int d = 0; d < 2; d++) begin
            now = model_exp(d, ecnt);
            if (v && now[12]) begin
                r.d = d;
                r.c = c;
                r.a = ecnt + 1;
                r.s = (r.a + 1 > last_s[d] + p_of(d) + g_of(d)) ? r.a + 1
                                                                 : last_s[d] + p_of(d) + g_of(d);
                last_s[d] = r.s;
                recs.push_back(r);
            end
        end
        @(posedge clk);
        ecnt++;
        @(negedge clk);
        chk("model_a", act_a, model_exp(0, ecnt));
        chk("model_b", act_b, model_exp(1, ecnt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        @(posedge clk);
        ecnt++;
        @(negedge clk);
        rst = 1'b1;
        model_clear();
    endtask

    initial begin
        logic       saw_full;
        int         kcyc, jcyc, ntr;
        logic [1:0] prev;
        int         seq[5];
        int         want[5];

        // {j,k}: 00 HOLD 01 CLR 10 SET 11 TOG; exp = {r, jk, busy, q, cnt}
        tbl[0]  = '{1'b1, 2'b10, ex(1, 0, 1, 0, 0)};
        tbl[1]  = '{1'b0, 2'b00, ex(1, 2, 1, 0, 0)};
        tbl[2]  = '{1'b0, 2'b00, ex(1, 0, 1, 1, 1)};
        tbl[3]  = '{1'b0, 2'b00, ex(1, 0, 0, 1, 1)};
        tbl[4]  = '{1'b1, 2'b11, ex(1, 0, 1, 1, 1)};
        tbl[5]  = '{1'b1, 2'b11, ex(1, 3, 1, 1, 1)};
        tbl[6]  = '{1'b1, 2'b11, ex(1, 0, 1, 0, 2)};
        tbl[7]  = '{1'b0, 2'b00, ex(1, 3, 1, 0, 2)};
        tbl[8]  = '{1'b0, 2'b00, ex(1, 0, 1, 1, 3)};
        tbl[9]  = '{1'b0, 2'b00, ex(1, 3, 1, 1, 3)};
        tbl[10] = '{1'b0, 2'b00, ex(1, 0, 1, 0, 4)};
        tbl[11] = '{1'b0, 2'b00, ex(1, 0, 0, 0, 4)};
        want = '{1, 2, 3, 0, 1};
        model_clear();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("in_reset_a", {ra, ja, ka, ba, qa, ca}, 13'h1000);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_a", act_a, 13'h1000);
        chk("reset_b", act_b, 13'h1000);

        // Single SET, then back-to-back TOGGLE x3
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v, tbl[i].c);
            chk($sformatf("tbl_%0d", i), act_a, tbl[i].exp);
        end

        // Overfill: continuous pushes must eventually see cmd_ready low
        saw_full = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 2'(i));
            if (!ra) saw_full = 1'b1;
        end
        chk("full_seen_a", 13'(saw_full), 13'd1);
        repeat (30) step(1'b0, 2'b00);

        // CLR, HOLD, SET with a 3-cycle pulse (instance B)
        kcyc = 0;
        jcyc = 0;
        step(1'b1, 2'b01);
        if (kb && !jb) kcyc++;
        if (jb && !kb) jcyc++;
        step(1'b1, 2'b00);
        if (kb && !jb) kcyc++;
        if (jb && !kb) jcyc++;
        step(1'b1, 2'b10);
        for (int i = 0; i < 30; i++) begin
            if (kb && !jb) kcyc++;
            if (jb && !kb) jcyc++;
            step(1'b0, 2'b00);
        end
        chk("clr_k_cycles_b", 13'(kcyc), 13'd3);
        chk("set_j_cycles_b", 13'(jcyc), 13'd3);
        chk("final_q_b", 13'(qb), 13'd1);

        // Reset mid-DRIVE with a TOGGLE in flight and one queued
        step(1'b1, 2'b11);
        step(1'b1, 2'b11);
        chk("pre_rst_drive_a", 13'({ja, ka}), 13'd3);
        cmd_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_a", act_a, 13'h1000);
        chk("async_rst_b", act_b, 13'h1000);
        @(posedge clk);
        ecnt++;
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        repeat (4) step(1'b0, 2'b00);

        // Counter wrap on B (CNT_W=2)
        do_reset();
        ntr  = 0;
        prev = cb;
        for (int i = 0; i < 40; i++) begin
            step(i < 5, 2'b00);
            if (cb != prev) begin
                if (ntr < 5) seq[ntr] = int'(cb);
                ntr++;
                prev = cb;
            end
        end
        chk("wrap_count_b", 13'(ntr), 13'd5);
        for (int i = 0; i < 5; i++)
            if (i < ntr) chk($sformatf("wrap_seq_%0d", i), 13'(seq[i]), 13'(want[i]));

        // Randomized traffic
        for (int i = 0; i < 600; i++)
            step(($urandom % 4) != 0, 2'($urandom));
        repeat (40) step(1'b0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
